// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if
// Groups the boot loader's UART and memory-write signals into one bundle.
//   rx_valid/rx_data        : received byte strobe and value (from UART RX)
//   tx_valid/tx_data/tx_ready : acknowledge byte handshake (to UART TX)
//   mem_we/mem_addr/mem_wdata/mem_ready : word write request to main memory
//   boot_go/boot_pc         : CPU start pulse and start address
//   overrun                 : sticky dropped-byte flag
// The slave modport is the loader; the master modport is its environment.
interface uart_boot_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        boot_go;
   logic [31:0] boot_pc;
   logic        overrun;

   modport slave (
      input  rx_valid, rx_data, tx_ready, mem_ready,
      output tx_valid, tx_data, mem_we, mem_addr, mem_wdata,
             boot_go, boot_pc, overrun
   );

   modport master (
      output rx_valid, rx_data, tx_ready, mem_ready,
      input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata,
             boot_go, boot_pc, overrun
   );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// Serial program-load engine. Decodes the loader command bytes arriving
// from the UART receiver, assembles big-endian 32-bit words, writes them to
// main memory, acknowledges each completed command with ACK_BYTE and, on
// the jump command, hands the CPU a start address.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : uart_boot_loader_if.slave (rx, tx, memory write, boot, overrun)
// All outputs are registered; each output register is loaded from the
// next-state decision so outputs line up with the state they belong to.
module uart_boot_loader #(
   parameter logic [31:0] RESET_ADDR = 32'h1000_0000,
   parameter logic [7:0]  ACK_BYTE   = 8'h66
) (
   input  logic               clk,
   input  logic               rst,
   uart_boot_loader_if.slave  bus
);

   localparam logic [7:0] CMD_ADDR = 8'h61;
   localparam logic [7:0] CMD_DATA = 8'h64;
   localparam logic [7:0] CMD_JUMP = 8'h6a;
   localparam logic [7:0] CMD_VER  = 8'h76;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE,
      S_ACK,
      S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_shift, w_shift_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic        r_overrun, w_overrun_nxt;
   logic        r_tx_valid, w_tx_valid_nxt;
   logic [7:0]  r_tx_data, w_tx_data_nxt;
   logic        r_mem_we, w_mem_we_nxt;
   logic [31:0] r_mem_addr, w_mem_addr_nxt;
   logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
   logic        r_boot_go, w_boot_go_nxt;
   logic [31:0] r_boot_pc, w_boot_pc_nxt;
   logic [31:0] w_word;

   // Word as it would look once the byte on rx_data is shifted in (MSB first)
   assign w_word = {r_shift[23:0], bus.rx_data};

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_shift_nxt     = r_shift;
      w_cnt_nxt       = r_cnt;
      w_overrun_nxt   = r_overrun;
      w_tx_data_nxt   = r_tx_data;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_boot_pc_nxt   = r_boot_pc;

      case (r_state)
         S_IDLE: begin
            if (bus.rx_valid) begin
               w_cnt_nxt = 2'd0;
               case (bus.rx_data)
                  CMD_ADDR: w_state_nxt = S_ADDR;
                  CMD_DATA: w_state_nxt = S_DATA;
                  CMD_VER:  w_state_nxt = S_ACK;
                  CMD_JUMP: begin
                     w_state_nxt   = S_DONE;
                     w_boot_pc_nxt = r_addr;
                  end
                  default:  w_state_nxt = S_IDLE;
               endcase
            end
         end

         S_ADDR: begin
            if (bus.rx_valid) begin
               w_shift_nxt = w_word;
               w_cnt_nxt   = r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  w_addr_nxt  = w_word;
                  w_state_nxt = S_ACK;
               end
            end
         end

         S_DATA: begin
            if (bus.rx_valid) begin
               w_shift_nxt = w_word;
               w_cnt_nxt   = r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  // Latch the write request here so it stays stable for the
                  // whole time mem_we is held waiting on mem_ready.
                  w_mem_addr_nxt  = {r_addr[31:2], 2'b00};
                  w_mem_wdata_nxt = w_word;
                  w_state_nxt     = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            if (bus.rx_valid) begin
               w_overrun_nxt = 1'b1;
            end
            if (bus.mem_ready) begin
               w_addr_nxt  = r_addr + 32'd4;
               w_state_nxt = S_ACK;
            end
         end

         S_ACK: begin
            if (bus.rx_valid) begin
               w_overrun_nxt = 1'b1;
            end
            if (bus.tx_ready) begin
               w_state_nxt = S_IDLE;
            end
         end

         S_DONE: begin
            // Terminal: everything received here is silently dropped.
            w_state_nxt = S_DONE;
         end

         default: w_state_nxt = S_IDLE;
      endcase

      w_mem_we_nxt   = (w_state_nxt == S_WRITE);
      w_tx_valid_nxt = (w_state_nxt == S_ACK);
      if (w_state_nxt == S_ACK) begin
         w_tx_data_nxt = ACK_BYTE;
      end
      // Pulse only on the DONE entry cycle
      w_boot_go_nxt  = (w_state_nxt == S_DONE) && (r_state != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_addr      <= RESET_ADDR;
         r_shift     <= 32'd0;
         r_cnt       <= 2'd0;
         r_overrun   <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= 8'd0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_boot_go   <= 1'b0;
         r_boot_pc   <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_shift     <= w_shift_nxt;
         r_cnt       <= w_cnt_nxt;
         r_overrun   <= w_overrun_nxt;
         r_tx_valid  <= w_tx_valid_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_boot_go   <= w_boot_go_nxt;
         r_boot_pc   <= w_boot_pc_nxt;
      end
   end

   assign bus.tx_valid  = r_tx_valid;
   assign bus.tx_data   = r_tx_data;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.boot_go   = r_boot_go;
   assign bus.boot_pc   = r_boot_pc;
   assign bus.overrun   = r_overrun;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Hardware program-load engine for the board's serial boot path. Consumes the byte stream from the UART receiver, decodes the loader command protocol, assembles big-endian 32-bit words and writes them into main memory. It acknowledges each completed command on the UART transmitter and, on the jump command, hands the CPU a start address. It sits between the UART core and the memory write port, in parallel with the CPU's own bus master, and is the writer-side counterpart of the boot ROM.

## Interface
- RESET_ADDR, 32'h10000000, initial load address after reset
- ACK_BYTE, 8'h66, byte sent to acknowledge a completed command
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  byte pending for transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts tx_data this cycle when tx_valid=1
- mem_we  out  1  memory write request, held until mem_ready
- mem_addr  out  32  write address, bits [1:0] forced to 0
- mem_wdata  out  32  write data
- mem_ready  in  1  memory completes the write this cycle
- boot_go  out  1  one-cycle pulse: CPU starts at boot_pc
- boot_pc  out  32  jump target, valid from boot_go onward
- overrun  out  1  sticky: a byte arrived while the engine could not accept it

## Operation
- Command bytes (IDLE only): 0x61 'a' = set address, 0x64 'd' = write word, 0x6a 'j' = jump, 0x76 'v' = version ping. Any other byte in IDLE is ignored, with no reply and no flag.
- States: IDLE, ADDR, DATA, WRITE, ACK, DONE.
- IDLE: 'a' -> ADDR; 'd' -> DATA; 'v' -> ACK; 'j' -> DONE. The byte counter clears on every command.
- ADDR: collect 4 bytes, MSB first, into the shift register. After the 4th byte, addr <= shift value and go to ACK.
- DATA: collect 4 bytes, MSB first. After the 4th byte, go to WRITE.
- WRITE: mem_we=1, mem_addr={addr[31:2],2'b00}, mem_wdata=assembled word. When mem_ready=1: addr <= addr+4 (mod 2^32, wraps 0xFFFFFFFC -> 0x00000000), then go to ACK.
- ACK: tx_valid=1, tx_data=ACK_BYTE. When tx_ready=1, go to IDLE.
- DONE: entered from 'j'. boot_pc <= addr and boot_go pulses on the entry cycle. The engine stays in DONE and ignores rx until reset.
- rx_valid is only accepted in IDLE, ADDR and DATA. rx_valid=1 in WRITE or ACK drops the byte and sets overrun. In DONE the byte is dropped and overrun is not set.
- overrun clears only on reset.

## Timing
- Reset values (rst=0 at a clock edge): state IDLE, addr=RESET_ADDR, shift register 0, byte counter 0, tx_valid=0, tx_data=0, mem_we=0, mem_addr=0, mem_wdata=0, boot_go=0, boot_pc=0, overrun=0.
- Reset mid-command (any state, including WRITE with mem_ready low) aborts the command. All outputs take their reset values on the next edge, and the partial word is discarded.
- Each byte is captured on the edge where rx_valid=1. The state change caused by that byte is visible the next cycle.
- 4th data byte at edge N -> mem_we=1 from cycle N+1. With mem_ready tied high, mem_we is high for exactly 1 cycle and tx_valid rises the following cycle.
- 4th address byte at edge N -> tx_valid=1 from cycle N+1.
- tx_valid stays high and tx_data stays stable until the tx_ready edge, then tx_valid=0 on the next cycle.
- mem_addr and mem_wdata stay stable while mem_we=1. mem_we falls the cycle after mem_ready.
- 'j' captured at edge N -> boot_go=1 during cycle N+1 only, and boot_pc is valid from cycle N+1.
- Back-to-back bytes (rx_valid on consecutive cycles) are accepted in ADDR and DATA.

## Test plan
- Reset then 'v' (0x76), tx_ready=1 -> tx_valid one cycle later with tx_data=0x66, then IDLE; no mem_we, overrun=0.
- 'a' 0x10 0x00 0x00 0x40, then 'd' 0xDE 0xAD 0xBE 0xEF, mem_ready=1 -> single write mem_addr=0x10000040, mem_wdata=0xDEADBEEF. Two ACK bytes 0x66 are sent, and addr becomes 0x10000044.
- Two 'd' commands with no prior 'a' -> writes land at 0x10000000 then 0x10000004. Hold mem_ready=0 for 5 cycles on the first write -> mem_we held with stable address and data for 6 cycles.
- 'a' FF FF FF FC, 'd' 00 00 00 01, then 'j' -> write at 0xFFFFFFFC, then a boot_go pulse with boot_pc=0x00000000. A later 'v' gets no reply.
- 'd' bytes, plus an rx_valid pulse during WRITE (mem_ready=0) -> byte dropped, overrun=1 and sticky, and the write data is unchanged. Unknown byte 0x55 in IDLE -> no reply, overrun unchanged.
- Assert rst=0 after 2 of 4 address bytes -> all outputs at reset values. A following 'd' 00 00 00 07 writes to 0x10000000.
